// File: rtl/fifo_sync_flags_pkg.sv
// Shared types, default sizing and helpers for the synchronous flag FIFO.
package fifo_sync_flags_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_AF_LEVEL   = DEF_FIFO_DEPTH - 2;
  localparam int DEF_AE_LEVEL   = 2;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // Fill-level width: one extra bit so that count == depth is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake bundle for the flag FIFO; slave is the FIFO side.
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = fifo_sync_flags_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_sync_flags_pkg::DEF_FIFO_DEPTH
);
  import fifo_sync_flags_pkg::*;

  logic                      Wr_enable;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      Read_enable;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output Wr_enable, data_in, Read_enable,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  Wr_enable, data_in, Read_enable,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_flags_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
module fifo_sync_flags_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered fill count, threshold flags, error pulses
// and selectable registered / first-word-fall-through read.
module fifo_sync_flags
  import fifo_sync_flags_pkg::*;
#(
  parameter int         DATA_WIDTH = fifo_sync_flags_pkg::DATA_WIDTH,
  parameter int         DEPTH      = DEF_FIFO_DEPTH,
  parameter int         AF_LEVEL   = DEPTH - 2,
  parameter int         AE_LEVEL   = DEF_AE_LEVEL,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic             clk,
  input  logic             reset,
  fifo_sync_flags_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of two and at least 4");
  end
  if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL < DEPTH)) begin : g_bad_levels
    $error("fifo_sync_flags: need 0 < AE_LEVEL < AF_LEVEL < DEPTH");
  end

  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  af_reg;
  logic                  ae_reg;
  logic                  ovf_reg;
  logic                  unf_reg;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // Acceptance uses registered flags only, so a write at full is dropped even
  // when a read pops in the same cycle.
  assign wr_ok = bus.Wr_enable   & ~full_reg;
  assign rd_ok = bus.Read_enable & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= 1'b0;
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
      ovf_reg   <= bus.Wr_enable   & full_reg;
      unf_reg   <= bus.Read_enable & empty_reg;
    end
  end

  fifo_sync_flags_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_reg;

    // Holds the last popped word, including across underflow.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_reg <= '0;
      end else if (rd_ok) begin
        dout_reg <= rd_data;
      end
    end
    assign bus.data_out = dout_reg;
  end else begin : g_fwft
    assign bus.data_out = empty_reg ? '0 : rd_data;
  end

  assign bus.count        = count_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = unf_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: STD and FWFT instances share stimulus and are checked every
// cycle against a queue model, plus hand-computed literal expectations.
module tb_fifo_sync_flags;
  import fifo_sync_flags_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bs ();
  fifo_sync_flags_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bf ();

  fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(1), .MODE(FIFO_STD))
    u_std (.clk(clk), .reset(reset), .bus(bs));
  fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(6), .AE_LEVEL(1), .MODE(FIFO_FWFT))
    u_fwft (.clk(clk), .reset(reset), .bus(bf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, STD output as last popped word.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_std_out;
  logic          m_ovf;
  logic          m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_std_out = '0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
    end else begin
      automatic bit was_full  = (mq.size() == DP);
      automatic bit was_empty = (mq.size() == 0);
      m_ovf = bs.Wr_enable & was_full;
      m_unf = bs.Read_enable & was_empty;
      if (bs.Read_enable && !was_empty) begin
        m_std_out = mq.pop_front();
      end
      if (bs.Wr_enable && !was_full) begin
        mq.push_back(bs.data_in);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      automatic int n = mq.size();
      automatic logic [DW-1:0] head = (n > 0) ? mq[0] : '0;
      chk("count",     32'(bs.count),        32'(n));
      chk("full",      32'(bs.full),         32'(n == DP));
      chk("empty",     32'(bs.empty),        32'(n == 0));
      chk("afull",     32'(bs.almost_full),  32'(n >= 6));
      chk("aempty",    32'(bs.almost_empty), 32'(n <= 1));
      chk("overflow",  32'(bs.overflow),     32'(m_ovf));
      chk("underflow", 32'(bs.underflow),    32'(m_unf));
      chk("std_dout",  32'(bs.data_out),     32'(m_std_out));
      chk("fw_count",  32'(bf.count),        32'(n));
      chk("fw_empty",  32'(bf.empty),        32'(n == 0));
      chk("fw_ovf",    32'(bf.overflow),     32'(m_ovf));
      chk("fw_unf",    32'(bf.underflow),    32'(m_unf));
      chk("fw_dout",   32'(bf.data_out),     32'(head));
    end
  end

  // Drive one cycle of stimulus from a negedge; returns at the next negedge.
  task automatic cyc(input logic we, input logic [DW-1:0] din, input logic re);
    bs.Wr_enable = we; bs.data_in = din; bs.Read_enable = re;
    bf.Wr_enable = we; bf.data_in = din; bf.Read_enable = re;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bs.Wr_enable = 1'b0; bs.data_in = '0; bs.Read_enable = 1'b0;
    bf.Wr_enable = 1'b0; bf.data_in = '0; bf.Read_enable = 1'b0;
    #3;
    chk("rst_count",  32'(bs.count),        32'd0);
    chk("rst_empty",  32'(bs.empty),        32'd1);
    chk("rst_aempty", 32'(bs.almost_empty), 32'd1);
    chk("rst_full",   32'(bs.full),         32'd0);
    chk("rst_afull",  32'(bs.almost_full),  32'd0);
    chk("rst_dout",   32'(bs.data_out),     32'd0);
    chk("rst_fwdout", 32'(bf.data_out),     32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);

    // 1: fill with 0x01..0x08
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 8'(k), 1'b0);
      chk("t1_count", 32'(bs.count), 32'(k));
      case (k)
        1: chk("t1_ae_at1", 32'(bs.almost_empty), 32'd1);
        2: chk("t1_ae_at2", 32'(bs.almost_empty), 32'd0);
        5: chk("t1_af_at5", 32'(bs.almost_full),  32'd0);
        6: chk("t1_af_at6", 32'(bs.almost_full),  32'd1);
        8: begin
          chk("t1_full", 32'(bs.full),     32'd1);
          chk("t1_ovf",  32'(bs.overflow), 32'd0);
        end
        default: ;
      endcase
    end

    // 2: overflow while full, then drain in STD order
    cyc(1'b1, 8'hAA, 1'b0);
    chk("t2_ovf",   32'(bs.overflow), 32'd1);
    chk("t2_count", 32'(bs.count),    32'd8);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_ovf_drop", 32'(bs.overflow), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("t2_fw_head", 32'(bf.data_out), 32'(k));
      cyc(1'b0, 8'h00, 1'b1);
      chk("t2_rd", 32'(bs.data_out), 32'(k));
    end
    chk("t2_empty", 32'(bs.empty), 32'd1);

    // 3: underflow
    cyc(1'b0, 8'h00, 1'b1);
    chk("t3_unf",    32'(bs.underflow), 32'd1);
    chk("t3_count",  32'(bs.count),     32'd0);
    chk("t3_hold",   32'(bs.data_out),  32'h08);
    chk("t3_fwdout", 32'(bf.data_out),  32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_unf_drop", 32'(bs.underflow), 32'd0);

    // 4: steady state at count 4 with simultaneous read/write, pointers wrap
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h21 + k), 1'b0);
    chk("t4_count4", 32'(bs.count), 32'd4);
    for (int k = 0; k < 10; k++) begin
      automatic logic [DW-1:0] exp_rd = (k < 4) ? 8'(8'h21 + k) : 8'(8'h10 + k - 4);
      cyc(1'b1, 8'(8'h10 + k), 1'b1);
      chk("t4_rd",    32'(bs.data_out), 32'(exp_rd));
      chk("t4_count", 32'(bs.count),    32'd4);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t4_tail", 32'(bs.data_out), 32'(8'h16 + k));
    end

    // 5: FWFT head visibility
    cyc(1'b1, 8'h5C, 1'b0);
    chk("t5_empty", 32'(bf.empty),    32'd0);
    chk("t5_head",  32'(bf.data_out), 32'h5C);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t5_empty2", 32'(bf.empty),    32'd1);
    chk("t5_zero",   32'(bf.data_out), 32'd0);

    // 6: asynchronous reset mid-cycle with 5 words stored
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h41 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_pre", 32'(bs.count), 32'd4);
    bs.Read_enable = 1'b0; bf.Read_enable = 1'b0;
    cyc(1'b1, 8'h46, 1'b0);
    chk("t6_count5", 32'(bs.count), 32'd5);
    bs.Wr_enable = 1'b0; bf.Wr_enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_count",  32'(bs.count),        32'd0);
    chk("t6_empty",  32'(bs.empty),        32'd1);
    chk("t6_aempty", 32'(bs.almost_empty), 32'd1);
    chk("t6_afull",  32'(bs.almost_full),  32'd0);
    chk("t6_dout",   32'(bs.data_out),     32'd0);
    chk("t6_fwdout", 32'(bf.data_out),     32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_rd", 32'(bs.data_out), 32'h33);
    cyc(1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Single-clock, parametrised synchronous FIFO. It is the next-generation buffer behind the team's FIFO interface.
- Generalises depth, width and programmable almost-full/almost-empty thresholds.
- Adds a fill-level count and overflow/underflow error pulses.
- Read mode is selectable: registered (standard) or first-word-fall-through (FWFT).
- Sits between producer and consumer blocks on the same clock domain.

Parameters:
- DATA_WIDTH, FIFO_pkg::DATA_WIDTH, width of each data word.
- DEPTH, 16, number of entries; power of two, minimum 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- MODE, FIFO_STD, FIFO_STD = registered read; FIFO_FWFT = head word visible on data_out.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Wr_enable  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- Read_enable  input  1  read request (in FWFT: pop/acknowledge of the current head).
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current number of stored words.
- overflow  output  1  one-cycle pulse: a write was rejected.
- underflow  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset: clk and reset are fixed as one clock plus an asynchronous active-high reset. While reset is high:
  - pointers = 0, count = 0, data_out = 0;
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - Reset mid-operation discards all contents immediately. Memory contents need not be cleared.
- Accept rules (evaluated on pre-edge state):
  - wr_ok = Wr_enable & !full; rd_ok = Read_enable & !empty.
  - A write while full is dropped, even if a read occurs in the same cycle.
- Count update:
  - wr_ok only: +1. rd_ok only: -1. Both: unchanged.
  - Simultaneous read and write at count 0 is illegal (rd_ok = 0), so only the write is accepted.
- Pointers:
  - Width $clog2(DEPTH); wrap naturally from DEPTH-1 to 0.
  - wr_ptr advances on wr_ok; rd_ptr advances on rd_ok.
- Flags: all registered and derived from the next count, so they change on the same edge as count. No combinational path from the enables to the flags.
- overflow: high for exactly one cycle after an edge where Wr_enable & full.
- underflow: high for exactly one cycle after an edge where Read_enable & empty.
- STD mode:
  - On rd_ok, data_out <= mem[rd_ptr]; valid the cycle after the edge (latency 1).
  - Otherwise data_out holds its last value, including across an underflow.
- FWFT mode:
  - data_out = mem[rd_ptr] combinationally when !empty, and 0 when empty.
  - The first written word appears on data_out one cycle after its write edge, i.e. when empty deasserts.
  - rd_ok pops the head; the next word (or 0) is visible after the edge.
- Write data is stored in mem[wr_ptr] on wr_ok.
- Parameter legality: 0 < AE_LEVEL < AF_LEVEL < DEPTH. Check with an elaboration-time assertion.

Decomposition:
- FIFO_pkg gains:
  - typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  - constants DEF_FIFO_DEPTH = 16, DEF_AF_LEVEL, DEF_AE_LEVEL;
  - function cnt_w(depth) returning $clog2(depth)+1.
- The existing intf gains almost_full, almost_empty, count, overflow and underflow. These are added as clocking-block inputs and as FIFO modport outputs.
- One sub-module: fifo_ram. It is a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port. The top level registers data_out in STD mode.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=1 unless noted):
1. Reset, then write 0x01..0x08 on 8 consecutive cycles -> count steps 1..8; almost_empty drops when count reaches 2; almost_full rises when count reaches 6; full=1 at count 8; no overflow.
2. When full, pulse Wr_enable with 0xAA for 1 cycle -> overflow=1 for one cycle; count stays 8. Draining 8 words (STD) returns 0x01..0x08, each one cycle after its Read_enable; 0xAA is never seen.
3. When empty, assert Read_enable -> underflow=1 for one cycle; count=0; data_out holds 0x08.
4. With count=4, assert Wr_enable and Read_enable together for 10 cycles with writes 0x10..0x19 -> count stays 4; reads return the 4 older words, then 0x10..0x15; pointers wrap past 7 without error.
5. MODE=FWFT: write 0x5C into an empty FIFO -> next cycle empty=0 and data_out=0x5C with no read; Read_enable for 1 cycle -> empty=1 and data_out=0.
6. With count=5, assert reset asynchronously mid-cycle -> outputs go to reset values before the next edge; after release, writing 0x33 then reading returns 0x33.
